coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have these parameters:
- BEV1_COST, default 125, price of beverage 1 in cents.
- BEV2_COST, default 220, price of beverage 2 in cents.
- BEV3_COST, default 175, price of beverage 3 in cents.
- MAX_CREDIT, default 1000, credit ceiling in cents.
- TIMEOUT_CYCLES, default 1000, idle-refund timeout in clocks.
REQ-002 The block SHALL have these ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, asynchronous active-high reset.
- coin_valid, input, 1, one-cycle coin-inserted strobe.
- coin_type, input, 2, 0=5c, 1=10c, 2=25c, 3=100c.
- cancel, input, 1, one-cycle strobe requesting a refund of the full credit.
- vend1 / vend2 / vend3, input, 1 each, one-cycle dispense strobes.
- moneyout, output, 10, current credit in cents; drives the dispenser's money input.
- coin_reject, output, 1, one-cycle pulse when a coin is returned unaccepted.
- chg_valid, output, 1, one-cycle pulse per change coin ejected.
- chg_type, output, 2, coin encoding identical to coin_type.
- busy, output, 1, high while in the CHANGE state.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and CHANGE, with a 10-bit credit register driving moneyout directly (registered, no combinational path from inputs).
REQ-004 In IDLE, a coin_valid SHALL add the coin value to credit on the next edge if credit + value <= MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses the next cycle.
REQ-005 In IDLE, a vendN strobe with credit >= BEVN_COST SHALL subtract the cost; if the remainder is nonzero the FSM enters CHANGE, else stays IDLE.
REQ-006 A vendN strobe with credit < BEVN_COST SHALL be ignored.
REQ-007 When more than one vend strobe is asserted, priority SHALL be vend1 > vend2 > vend3; only the winning cost is subtracted.
REQ-008 A vend and a coin_valid in the same cycle SHALL resolve as: vend wins, and the coin is rejected (coin_reject pulse).
REQ-009 cancel in IDLE with credit > 0 SHALL enter CHANGE with credit unchanged; cancel with credit = 0 SHALL be ignored.
REQ-010 Priority among simultaneous IDLE events SHALL be vend > cancel > coin.
REQ-011 In CHANGE, each cycle SHALL eject one coin: the largest coin value <= credit, with chg_valid=1, chg_type set accordingly, and credit decremented by that value on the same edge.
REQ-012 The FSM SHALL return to IDLE on the edge that brings credit to 0; chg_valid is low in IDLE.
REQ-013 In CHANGE, coin_valid SHALL be rejected, and vend and cancel SHALL be ignored.
REQ-014 Credit SHALL always be a multiple of 5 and SHALL never underflow or exceed MAX_CREDIT.

Reset
REQ-015 While rst=1, the block SHALL hold: state=IDLE, credit=0, moneyout=0, coin_reject=0, chg_valid=0, chg_type=0, busy=0, and timeout counter=0.
REQ-016 An assertion of rst mid-CHANGE SHALL abort change ejection immediately, with no further chg_valid pulses.

Configuration
REQ-017 When IDLE_REFUND_EN is defined, a 10-bit-or-wider counter SHALL increment each IDLE cycle while credit > 0, clear on any accepted coin or on credit = 0, and enter CHANGE (full refund) when it reaches TIMEOUT_CYCLES.
REQ-018 When IDLE_REFUND_EN is undefined, no counter SHALL exist and credit SHALL be held indefinitely.

Verification
REQ-019 Reset, then insert 100,25 -> moneyout=125; vend1 -> moneyout=0, busy stays 0, no chg_valid.
REQ-020 Insert 100,100,25 (225), vend2 -> change pulses 5c only; with credit 300 and vend3 -> 100c then 25c pulses, busy high 2 cycles.
REQ-021 Credit 1000, insert 5c -> coin_reject pulse, moneyout stays 1000.
REQ-022 Credit 150, vend2 -> ignored; the same cycle with vend1+vend3 -> 125 deducted, change 25c.
REQ-023 Credit 40, cancel -> chg_type sequence 25,10,5; a coin inserted during CHANGE -> rejected; rst asserted mid-sequence -> all outputs 0 at once.
REQ-024 With IDLE_REFUND_EN defined and TIMEOUT_CYCLES=8, insert 10c and idle -> refund of 10c starts after 8 cycles.

Source files
------------

// File: rtl/coin_acceptor.sv
// Vending coin acceptor: accumulates credit, vends three beverages and pays change one coin per cycle.
// Optional macro IDLE_REFUND_EN adds an idle timer that refunds the held credit after TIMEOUT_CYCLES.
module coin_acceptor #(
  parameter int unsigned BEV1_COST      = 125,
  parameter int unsigned BEV2_COST      = 220,
  parameter int unsigned BEV3_COST      = 175,
  parameter int unsigned MAX_CREDIT     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       vend1,
  input  logic       vend2,
  input  logic       vend3,
  output logic [9:0] moneyout,
  output logic       coin_reject,
  output logic       chg_valid,
  output logic [1:0] chg_type,
  output logic       busy
);

  // All inputs are single-cycle strobes sampled on posedge clk; there is no back-pressure.
  // Every output is a Moore function of registered state, so nothing is combinational from inputs.
  typedef enum logic {S_IDLE = 1'b0, S_CHANGE = 1'b1} state_t;

  localparam logic [9:0]  C_BEV1 = 10'(BEV1_COST);
  localparam logic [9:0]  C_BEV2 = 10'(BEV2_COST);
  localparam logic [9:0]  C_BEV3 = 10'(BEV3_COST);
  localparam logic [10:0] C_MAX  = 11'(MAX_CREDIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_credit;
  logic [9:0]  w_credit_nxt;
  logic        r_coin_reject;
  logic        w_reject_nxt;
  logic [9:0]  w_coin_val;
  logic [10:0] w_sum;
  logic [9:0]  w_cost;
  logic        w_vend_any;
  logic        w_vend_ok;
  logic [9:0]  w_chg_val;
  logic [1:0]  w_chg_code;
  logic        w_timeout;

  always_comb begin
    unique case (coin_type)
      2'd0:    w_coin_val = 10'd5;
      2'd1:    w_coin_val = 10'd10;
      2'd2:    w_coin_val = 10'd25;
      default: w_coin_val = 10'd100;
    endcase
  end

  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

  // Highest-priority asserted strobe wins; if it is unaffordable the whole vend request is dropped.
  always_comb begin
    w_vend_any = vend1 | vend2 | vend3;
    if (vend1)      w_cost = C_BEV1;
    else if (vend2) w_cost = C_BEV2;
    else            w_cost = C_BEV3;
    w_vend_ok = w_vend_any && (r_credit >= w_cost);
  end

  // Greedy change: credit is always a multiple of 5, so a 5c coin always fits.
  always_comb begin
    if (r_credit >= 10'd100) begin
      w_chg_val  = 10'd100;
      w_chg_code = 2'd3;
    end else if (r_credit >= 10'd25) begin
      w_chg_val  = 10'd25;
      w_chg_code = 2'd2;
    end else if (r_credit >= 10'd10) begin
      w_chg_val  = 10'd10;
      w_chg_code = 2'd1;
    end else begin
      w_chg_val  = 10'd5;
      w_chg_code = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= 10'd0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_coin_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_reject_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_vend_ok) begin
          w_credit_nxt = r_credit - w_cost;
          w_state_nxt  = (r_credit != w_cost) ? S_CHANGE : S_IDLE;
          w_reject_nxt = coin_valid;
        end else if (cancel && (r_credit != 10'd0)) begin
          w_state_nxt  = S_CHANGE;
          w_reject_nxt = coin_valid;
        end else if (coin_valid) begin
          if (w_sum <= C_MAX) w_credit_nxt = w_sum[9:0];
          else                w_reject_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_CHANGE;
        end
      end
      S_CHANGE: begin
        w_reject_nxt = coin_valid;
        if (r_credit <= w_chg_val) begin
          w_credit_nxt = 10'd0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_credit_nxt = r_credit - w_chg_val;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_CHANGE);
    chg_valid = busy;
    chg_type  = busy ? w_chg_code : 2'd0;
  end

  assign moneyout    = r_credit;
  assign coin_reject = r_coin_reject;

`ifdef IDLE_REFUND_EN
  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_idle_cnt;

  // The edge on which the counter would reach the timeout is the edge that enters CHANGE.
  assign w_timeout = (r_state == S_IDLE) && (r_credit != 10'd0) &&
                     ((r_idle_cnt + 16'd1) >= C_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= 16'd0;
    end else if ((r_state != S_IDLE) || (r_credit == 10'd0) ||
                 (coin_valid && !w_reject_nxt)) begin
      r_idle_cnt <= 16'd0;
    end else if (r_idle_cnt != C_TIMEOUT) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  // No refund timer: credit is held until a vend or cancel.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
